// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_ctrl_pkg                                                     |
// | Purpose  : Shared widths, run-control state type and defaults for the      |
// |            program-counter controller and its next-address calculator.     |
// | Contents : ADDR_W, RET_W, RESET_VECTOR_DEF, pc_state_t, is_halt_like()     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package pc_ctrl_pkg;

  // PC width in words and width of the retired-instruction counter.
  localparam int ADDR_W = 5;
  localparam int RET_W  = 16;

  // Default PC loaded while reset is held.
  localparam logic [ADDR_W-1:0] RESET_VECTOR_DEF = 5'd0;

  // Run-control states. Encoding 2'd3 is unused and treated as HALT.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } pc_state_t;

  // Anything that is neither RUN nor STEP (including the unused encoding)
  // parks the core.
  function automatic logic is_halt_like(input pc_state_t s);
    return (s != RUN) && (s != STEP);
  endfunction

endpackage : pc_ctrl_pkg
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_next_calc                                                    |
// | Purpose  : Combinational "normal" next-PC selection: jump target, taken    |
// |            branch (PC+1 relative) or sequential fetch, in that priority.   |
// | Ports    : addr          in  current PC                                    |
// |            jump          in  current instruction is a jump                 |
// |            jump_target   in  absolute jump word address                    |
// |            branch_taken  in  current instruction is a taken branch         |
// |            branch_offset in  signed word offset relative to addr+1         |
// |            nrm           out selected next address                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pc_next_calc
  import pc_ctrl_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] nrm
);

  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_br;

  // Address arithmetic is modulo 2**ADDR_W, so 31 + 1 wraps to 0.
  assign w_seq = addr + ADDR_W'(1);

  // The offset is as wide as the PC, so a plain modular add already gives
  // the sign-extended result: no explicit extension is needed.
  assign w_br = w_seq + branch_offset;

  // Jump outranks branch when a decoder glitch raises both.
  always_comb begin
    nrm = w_seq;
    if (jump) begin
      nrm = jump_target;
    end else if (branch_taken) begin
      nrm = w_br;
    end
  end

endmodule : pc_next_calc
`default_nettype wire

// File: rtl/pc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_controller                                                   |
// | Purpose  : Run-control sequencer for the PC register. Chooses next_addr    |
// |            each cycle (reset / halt hold / jump / branch / sequential),    |
// |            runs the RUN-HALT-STEP debug state machine, gates commits and   |
// |            counts retired instructions.                                    |
// | Ports    : clk, rst_n (sync, active-low)                                   |
// |            addr                          current PC                        |
// |            run_req, step_req, halt_req   debug run-control requests        |
// |            halt_insn                     decoder: halt opcode              |
// |            jump, jump_target             decoder: absolute jump            |
// |            branch_taken, branch_offset   ALU/decoder: taken branch         |
// |            next_addr                     value PC loads at next edge       |
// |            exec_en                       commit gate for RF / DMEM writes  |
// |            halted                        state is HALT                     |
// |            retired                       retired-instruction count         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pc_controller
  import pc_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter bit                BOOT_HALTED  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              halt_req,
  input  logic              halt_insn,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] next_addr,
  output logic              exec_en,
  output logic              halted,
  output logic [RET_W-1:0]  retired
);

  localparam pc_state_t BOOT_STATE = BOOT_HALTED ? HALT : RUN;

  pc_state_t         state_q;
  logic [RET_W-1:0]  retired_q;
  logic [RET_W-1:0]  retired_d;
  logic [ADDR_W-1:0] w_nrm;

  pc_next_calc u_next_calc (
    .addr          (addr),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .nrm           (w_nrm)
  );

  // Output muxing. Holding the PC means feeding addr straight back, since
  // the PC register has no enable of its own. An external halt in RUN
  // squashes the current instruction rather than letting it commit.
  always_comb begin
    next_addr = addr;
    exec_en   = 1'b0;
    if (!rst_n) begin
      next_addr = RESET_VECTOR;
    end else begin
      case (state_q)
        RUN: begin
          if (!halt_req) begin
            exec_en   = 1'b1;
            next_addr = w_nrm;
          end
        end
        STEP: begin
          exec_en   = 1'b1;
          next_addr = w_nrm;
        end
        default: begin
          next_addr = addr;
          exec_en   = 1'b0;
        end
      endcase
    end
  end

  assign halted = is_halt_like(state_q);

  // Every committed instruction retires; the counter wraps silently.
  assign retired_d = retired_q + RET_W'(exec_en);
  assign retired   = retired_q;

  // Run-control FSM. A halt opcode in RUN still retires (exec_en is high)
  // and lands in HALT with the PC already past it. STEP ignores all
  // requests so a single step always completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= BOOT_STATE;
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
      case (state_q)
        RUN: begin
          if (halt_req || halt_insn) begin
            state_q <= HALT;
          end
        end
        STEP: begin
          state_q <= HALT;
        end
        default: begin
          // HALT and the unused encoding: run wins over step.
          if (run_req) begin
            state_q <= RUN;
          end else if (step_req) begin
            state_q <= STEP;
          end else begin
            state_q <= HALT;
          end
        end
      endcase
    end
  end

endmodule : pc_controller
`default_nettype wire

// File: tb/tb_pc_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pc_controller                                                |
// | Purpose  : Self-checking bench for pc_controller: directed scenarios plus  |
// |            randomized run-control traffic, scored against a behavioural    |
// |            model through an expected-response queue.                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pc_controller;

  localparam logic [4:0] RV = 5'd4;
  localparam bit         BOOT = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  addr;
  logic        run_req, step_req, halt_req, halt_insn, jump, branch_taken;
  logic [4:0]  jump_target, branch_offset;
  logic [4:0]  next_addr;
  logic        exec_en, halted;
  logic [15:0] retired;

  pc_controller #(.RESET_VECTOR(RV), .BOOT_HALTED(BOOT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .addr          (addr),
    .run_req       (run_req),
    .step_req      (step_req),
    .halt_req      (halt_req),
    .halt_insn     (halt_insn),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .next_addr     (next_addr),
    .exec_en       (exec_en),
    .halted        (halted),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  na;
    logic        en;
    logic        hl;
    logic [15:0] ret;
    int          idx;
  } exp_t;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   drive_idx  = 0;

  // Behavioural model: "parked" / "single-stepping" flags and a plain integer
  // retire count; pending values take effect at the clock edge.
  bit m_parked, m_stepping, p_parked, p_stepping;
  int m_ret, p_ret, p_addr;

  function automatic int nrm_f(int a, bit j, int jt, bit bt, int bo);
    int off;
    off = (bo >= 16) ? bo - 32 : bo;
    if (j) return jt;
    if (bt) return (((a + 1 + off) % 32) + 32) % 32;
    return (a + 1) % 32;
  endfunction

  task automatic drive(input bit rn, input bit rr, input bit sr, input bit hr,
                       input bit hi, input bit j, input logic [4:0] jt,
                       input bit bt, input logic [4:0] bo);
    exp_t e;
    int   nrm, na;
    bit   en;
    rst_n = rn; run_req = rr; step_req = sr; halt_req = hr; halt_insn = hi;
    jump = j; jump_target = jt; branch_taken = bt; branch_offset = bo;
    nrm = nrm_f(int'(addr), j, int'(jt), bt, int'(bo));
    if (!rn)                    begin en = 0; na = int'(RV);   end
    else if (m_stepping)        begin en = 1; na = nrm;        end
    else if (m_parked || hr)    begin en = 0; na = int'(addr); end
    else                        begin en = 1; na = nrm;        end
    e.na = 5'(na); e.en = en; e.hl = m_parked; e.ret = 16'(m_ret); e.idx = drive_idx;
    drive_idx++;
    q.push_back(e);
    if (!rn) begin
      p_parked = BOOT; p_stepping = 0; p_ret = 0;
    end else begin
      p_ret = en ? (m_ret + 1) % 65536 : m_ret;
      if (m_stepping) begin
        p_stepping = 0; p_parked = 1;
      end else if (m_parked) begin
        p_stepping = !rr && sr;
        p_parked   = !rr && !sr;
      end else begin
        p_stepping = 0; p_parked = hr || hi;
      end
    end
    p_addr = na;
    #2;
  endtask

  task automatic idle(input bit rn);
    drive(rn, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_parked = p_parked; m_stepping = p_stepping; m_ret = p_ret;
    addr = 5'(p_addr);
  endtask

  task automatic dchk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every cycle the DUT presents a response, compare the oldest
  // outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (next_addr !== e.na || exec_en !== e.en || halted !== e.hl || retired !== e.ret) begin
          miscompares++;
          $display("FAIL cycle%0d: next_addr=%0d exec_en=%0b halted=%0b retired=%0d, expected %0d %0b %0b %0d",
                   e.idx, next_addr, exec_en, halted, retired, e.na, e.en, e.hl, e.ret);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; addr = 5'd17; run_req = 0; step_req = 0; halt_req = 0; halt_insn = 0;
    jump = 0; jump_target = 0; branch_taken = 0; branch_offset = 0;
    m_parked = 0; m_stepping = 0; m_ret = 0;
    @(posedge clk); #1;

    // Reset: PC forced to the reset vector, nothing commits.
    idle(0); dchk("reset_next_addr", int'(next_addr), 4); dchk("reset_exec_en", int'(exec_en), 0);
    tick(); idle(0); tick();
    dchk("boot_retired", int'(retired), 0);

    // Free run 4..31 then wrap to 0.
    for (int i = 0; i < 28; i++) begin
      dchk("seq_addr", int'(addr), 4 + i);
      idle(1); tick();
    end
    dchk("retired_after_28", int'(retired), 28);
    idle(1); dchk("wrap_next_addr", int'(next_addr), 1); tick();

    // Branch back by 4 from 10, then jump beating a branch.
    addr = 5'd10; drive(1, 0, 0, 0, 0, 0, 5'd0, 1, 5'b11100);
    dchk("branch_neg4", int'(next_addr), 7); tick();
    addr = 5'd10; drive(1, 0, 0, 0, 0, 1, 5'd3, 1, 5'b11100);
    dchk("jump_over_branch", int'(next_addr), 3); tick();

    // Halt opcode at 12 retires and parks at 13; run resumes there.
    addr = 5'd12; drive(1, 0, 0, 0, 1, 0, 5'd0, 0, 5'd0);
    dchk("halt_insn_next", int'(next_addr), 13); tick();
    idle(1); dchk("halted_after_insn", int'(halted), 1); dchk("pc_held", int'(next_addr), 13); tick();
    drive(1, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0); tick();
    idle(1); dchk("resume_next", int'(next_addr), 14); tick();

    // External halt at 20 squashes the instruction.
    addr = 5'd20; drive(1, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0);
    dchk("halt_req_en", int'(exec_en), 0); dchk("halt_req_pc", int'(next_addr), 20); tick();
    idle(1); dchk("halt_req_state", int'(halted), 1); tick();

    // Single step from 5.
    addr = 5'd5; drive(1, 0, 1, 0, 0, 0, 5'd0, 0, 5'd0); tick();
    idle(1); dchk("step_next", int'(next_addr), 6); dchk("step_en", int'(exec_en), 1); tick();
    idle(1); dchk("after_step_halted", int'(halted), 1); dchk("after_step_pc", int'(next_addr), 6); tick();
    drive(1, 1, 1, 0, 0, 0, 5'd0, 0, 5'd0); tick();
    idle(1); dchk("run_wins", int'(halted), 0); tick();

    // Reset landing on a STEP cycle.
    drive(1, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0); tick();
    drive(1, 0, 1, 0, 0, 0, 5'd0, 0, 5'd0); tick();
    idle(0); dchk("rst_in_step_pc", int'(next_addr), 4); dchk("rst_in_step_en", int'(exec_en), 0); tick();
    idle(1); dchk("rst_in_step_ret", int'(retired), 0); dchk("rst_in_step_state", int'(halted), 0); tick();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) addr = 5'($urandom);
      drive($urandom_range(0, 63) != 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 5) == 0,
            5'($urandom),
            $urandom_range(0, 2) == 0,
            5'($urandom));
      tick();
    end

    @(negedge clk); #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pc_controller
`default_nettype wire
